gpu_frame_scheduler: RTL and testbench

//  Sequences one frame of vertex batches into the Q16 GPU pipeline (vertex shader -> hex rasterizer
//  -> event writer / hex-to-screen). Issues frame_start, then admits batches under a credit limit.

---
 rtl/gpu_frame_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_gpu_frame_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gpu_frame_scheduler.sv
// Frame scheduler for the Q16 GPU pipeline: pulses frame_start, admits batches under a credit and
// event-memory limit, tracks in-flight batches and reports completion. Optional: GPU_SCHED_WATCHDOG_EN.
module gpu_frame_scheduler #(
  parameter int BATCH        = 10,
  parameter int MEM_DEPTH    = 256,
  parameter int MAX_INFLIGHT = 4
`ifdef GPU_SCHED_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES  = 1024
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_req,
  input  logic [15:0] frame_batches,
  input  logic        batch_valid,
  output logic        batch_ready,
  output logic        in_valid,
  output logic        frame_start,
  input  logic        rast_valid,
  input  logic [31:0] mem_write_count,
  output logic        busy,
  output logic        frame_done,
  output logic        mem_full,
  output logic        proto_err,
  output logic        timeout,
  output logic [15:0] batches_issued
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0] INFL_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] INFL_ONE  = IW'(1);
  localparam logic [IW-1:0] INFL_MAX  = IW'(MAX_INFLIGHT);
  localparam logic [32:0]   DEPTH_33  = 33'(MEM_DEPTH);
  localparam logic [32:0]   BATCH_33  = 33'(BATCH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [15:0]   remaining;
  logic [IW-1:0] inflight;
  logic [IW:0]   inflight_inc;
  logic [32:0]   mem_need;
  logic          fits;
  logic          accept;
  logic          rast_ok;
  logic          wdog_fire;

  // Worst case if one more batch is admitted: every in-flight batch plus the new one writes BATCH
  // entries. Evaluated at 33 bits so a fill level near 2^32 cannot wrap into a false fit.
  assign inflight_inc = {1'b0, inflight} + {{IW{1'b0}}, 1'b1};
  assign mem_need     = {1'b0, mem_write_count} + (33'(inflight_inc) * BATCH_33);
  assign fits         = (mem_need <= DEPTH_33);

  assign batch_ready = (state == S_ISSUE) && (remaining != 16'd0) &&
                       (inflight < INFL_MAX) && fits;
  assign accept      = batch_valid && batch_ready;
  assign in_valid    = accept;
  assign rast_ok     = rast_valid && (inflight != INFL_ZERO);

`ifdef GPU_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_cnt;
  logic          wdog_count_en;

  assign wdog_count_en = ((state == S_ISSUE) || (state == S_DRAIN)) &&
                         (inflight != INFL_ZERO) && !rast_valid;
  assign wdog_fire     = wdog_count_en && (wdog_cnt == WDOG_LAST);

  // Stall counter: runs only while batches are outstanding and the rasterizer is silent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt <= {WW{1'b0}};
    end else if (wdog_count_en && !wdog_fire) begin
      wdog_cnt <= wdog_cnt + WW'(1);
    end else begin
      wdog_cnt <= {WW{1'b0}};
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  // Frame FSM, credit tracking and all registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      remaining      <= 16'd0;
      inflight       <= INFL_ZERO;
      busy           <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      mem_full       <= 1'b0;
      proto_err      <= 1'b0;
      timeout        <= 1'b0;
      batches_issued <= 16'd0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      if (wdog_fire) begin
        inflight <= INFL_ZERO;
      end else if (accept && !rast_ok) begin
        inflight <= inflight + INFL_ONE;
      end else if (rast_ok && !accept) begin
        inflight <= inflight - INFL_ONE;
      end else begin
        inflight <= inflight;
      end

      case (state)
        S_IDLE: begin
          if (frame_req) begin
            remaining      <= frame_batches;
            batches_issued <= 16'd0;
            mem_full       <= 1'b0;
            proto_err      <= 1'b0;
            timeout        <= 1'b0;
            frame_start    <= 1'b1;
            busy           <= 1'b1;
            state          <= S_CLEAR;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (accept) begin
            remaining      <= remaining - 16'd1;
            batches_issued <= batches_issued + 16'd1;
          end else begin
            remaining <= remaining;
          end
          if (wdog_fire) begin
            timeout    <= 1'b1;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else if (remaining == 16'd0) begin
            state <= S_DRAIN;
          end else if (!fits && (inflight == INFL_ZERO)) begin
            // Nothing left to retire, so memory will never make room for the next batch.
            mem_full <= 1'b1;
            state    <= S_DRAIN;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (wdog_fire) begin
            timeout    <= 1'b1;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else if (inflight == INFL_ZERO) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            state <= S_DRAIN;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase

      // A retire pulse with nothing outstanding is a pipeline protocol violation.
      if (rast_valid && (inflight == INFL_ZERO)) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpu_frame_scheduler.sv
// Directed bench for gpu_frame_scheduler (BATCH=10, MEM_DEPTH=25, MAX_INFLIGHT=2) with
// per-cycle expected in_valid / batch_ready / frame_done / busy patterns.
module tb_gpu_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_req;
  logic [15:0] frame_batches;
  logic        batch_valid;
  logic        batch_ready;
  logic        in_valid;
  logic        frame_start;
  logic        rast_valid;
  logic [31:0] mem_write_count;
  logic        busy;
  logic        frame_done;
  logic        mem_full;
  logic        proto_err;
  logic        timeout;
  logic [15:0] batches_issued;

  int n_err    = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  gpu_frame_scheduler #(
    .BATCH(10),
    .MEM_DEPTH(25),
    .MAX_INFLIGHT(2)
`ifdef GPU_SCHED_WATCHDOG_EN
    ,
    .WDOG_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_req(frame_req),
    .frame_batches(frame_batches),
    .batch_valid(batch_valid),
    .batch_ready(batch_ready),
    .in_valid(in_valid),
    .frame_start(frame_start),
    .rast_valid(rast_valid),
    .mem_write_count(mem_write_count),
    .busy(busy),
    .frame_done(frame_done),
    .mem_full(mem_full),
    .proto_err(proto_err),
    .timeout(timeout),
    .batches_issued(batches_issued)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request in cycle t; frame_start must be high in t+1. Returns at the first ISSUE cycle.
  task automatic start_frame(input string tag, input logic [15:0] nb);
    frame_req     = 1'b1;
    frame_batches = nb;
    @(negedge clk);
    check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_idle_fstart"}, 32'(frame_start), 32'd0);
    tick();
    frame_req = 1'b0;
    @(negedge clk);
    check_val({tag, "_fstart"}, 32'(frame_start), 32'd1);
    check_val({tag, "_clr_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_clr_ready"}, 32'(batch_ready), 32'd0);
    check_val({tag, "_clr_perr"}, 32'(proto_err), 32'd0);
    tick();
  endtask

  // Drive rast pattern rv and compare outputs against hand-derived patterns, cycle by cycle.
  task automatic run_vec(input string tag, input int n, input logic [31:0] iv,
                         input logic [31:0] rv, input int done_idx, input int mem_step);
    for (int c = 0; c < n; c++) begin
      rast_valid = rv[c];
      if (rv[c]) mem_write_count = mem_write_count + 32'(mem_step);
      @(negedge clk);
      check_val($sformatf("%s_in_valid_c%0d", tag, c), 32'(in_valid), 32'(iv[c]));
      check_val($sformatf("%s_ready_c%0d", tag, c), 32'(batch_ready), 32'(iv[c]));
      check_val($sformatf("%s_done_c%0d", tag, c), 32'(frame_done), 32'(c == done_idx));
      check_val($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= done_idx));
      check_val($sformatf("%s_fstart_c%0d", tag, c), 32'(frame_start), 32'd0);
      tick();
    end
    rast_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int done_seen;
    reset           = 1'b1;
    frame_req       = 1'b0;
    frame_batches   = 16'd0;
    batch_valid     = 1'b1;
    rast_valid      = 1'b0;
    mem_write_count = 32'd0;

    @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fstart", 32'(frame_start), 32'd0);
    check_val("rst_fdone", 32'(frame_done), 32'd0);
    check_val("rst_ready", 32'(batch_ready), 32'd0);
    check_val("rst_issued", 32'(batches_issued), 32'd0);
    check_val("rst_flags", {29'd0, mem_full, proto_err, timeout}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // T1: 3 batches, 4-cycle rasterizer; accept and retire coincide at c5 (inflight stays 1)
    start_frame("t1", 16'd3);
    run_vec("t1", 13, 32'h0000_0023, 32'h0000_0230, 11, 0);
    check_val("t1_issued", 32'(batches_issued), 32'd3);
    check_val("t1_flags", {29'd0, mem_full, proto_err, timeout}, 32'd0);

    // T2: credit limit 2, rasterizer stalled; each retire frees exactly one accept
    start_frame("t2", 16'd5);
    run_vec("t2", 21, 32'h0000_2443, 32'h0003_1220, 19, 0);
    check_val("t2_issued", 32'(batches_issued), 32'd5);
    check_val("t2_flags", {29'd0, mem_full, proto_err, timeout}, 32'd0);

    // T3: writer adds 10 per retire; third batch never fits 25 entries
    mem_write_count = 32'd0;
    start_frame("t3", 16'd5);
    run_vec("t3", 11, 32'h0000_0003, 32'h0000_0050, 9, 10);
    check_val("t3_issued", 32'(batches_issued), 32'd2);
    check_val("t3_mem_full", 32'(mem_full), 32'd1);
    check_val("t3_perr", 32'(proto_err), 32'd0);

    // T4: one batch, extra retire in DRAIN at inflight 0 -> proto_err
    mem_write_count = 32'd0;
    start_frame("t4", 16'd1);
    run_vec("t4", 7, 32'h0000_0001, 32'h0000_0018, 5, 0);
    check_val("t4_perr", 32'(proto_err), 32'd1);
    check_val("t4_issued", 32'(batches_issued), 32'd1);
    check_val("t4_mem_full", 32'(mem_full), 32'd0);

    // T5: asynchronous reset mid-ISSUE with two batches outstanding
    start_frame("t5", 16'd5);
    tick();
    tick();
    check_val("t5_pre_issued", 32'(batches_issued), 32'd2);
    check_val("t5_pre_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_issued", 32'(batches_issued), 32'd0);
    check_val("t5_rst_ready", 32'(batch_ready), 32'd0);
    check_val("t5_rst_invalid", 32'(in_valid), 32'd0);
    check_val("t5_rst_flags", {29'd0, mem_full, proto_err, timeout}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("t5_rst_fdone_%0d", i), 32'(frame_done), 32'd0);
      tick();
    end
    reset = 1'b0;
    tick();

    // T5b: empty frame -> frame_done three cycles after frame_start, no inflight underflow
    start_frame("t5z", 16'd0);
    run_vec("t5z", 5, 32'h0000_0000, 32'h0000_0000, 2, 0);
    check_val("t5z_issued", 32'(batches_issued), 32'd0);
    check_val("t5z_flags", {29'd0, mem_full, proto_err, timeout}, 32'd0);

    // T6: one batch, rasterizer never answers
    start_frame("t6", 16'd1);
`ifdef GPU_SCHED_WATCHDOG_EN
    run_vec("t6", 19, 32'h0000_0001, 32'h0000_0000, 17, 0);
    check_val("t6_timeout", 32'(timeout), 32'd1);
    check_val("t6_issued", 32'(batches_issued), 32'd1);
`else
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done) done_seen++;
      tick();
    end
    check_val("t6_busy_hold", 32'(busy), 32'd1);
    check_val("t6_no_done", 32'(done_seen), 32'd0);
    check_val("t6_timeout", 32'(timeout), 32'd0);
    check_val("t6_issued", 32'(batches_issued), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
